// File: rtl/phy_stage_checker.sv
// Per-channel checker: compares sampled data against a registered reference ROM, counts mismatches.
// Latency: compare one clock after sample acceptance; done/pass update on that compare edge.
// Backpressure: none; valid_in accepted every cycle while in RUN (single-shot holds off once the last sample is in flight).
module phy_stage_checker #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 1,
    parameter int VEC_LEN = 192,
    parameter int ERR_W   = 16,
    localparam int IDX_W  = $clog2(VEC_LEN)
) (
    input  logic                      clk_ref,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic [NUM_CH-1:0]         valid_in,
    input  logic [NUM_CH*DATA_W-1:0]  data_in,
    output logic [NUM_CH*IDX_W-1:0]   exp_addr,
    input  logic [NUM_CH*DATA_W-1:0]  exp_data,
    output logic [NUM_CH-1:0]         ready_out,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         pass,
    output logic [NUM_CH*ERR_W-1:0]   err_cnt,
    output logic [NUM_CH*IDX_W-1:0]   first_err_idx,
    output logic                      all_pass
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Mode is latched once per start and shared by every channel.
    logic mode_r;

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            mode_r <= 1'b0;
        end else if (start) begin
            mode_r <= mode;
        end
    end

    genvar c;
    for (c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]        st;
        logic [IDX_W-1:0]  idx;
        logic [IDX_W-1:0]  pend_idx;
        logic [IDX_W-1:0]  first_idx;
        logic [DATA_W-1:0] pend_dat;
        logic [DATA_W-1:0] smp_dat;
        logic [DATA_W-1:0] ref_dat;
        logic [ERR_W-1:0]  errs;
        logic [ERR_W-1:0]  errs_nxt;
        logic              pend;
        logic              first_seen;
        logic              done_r;
        logic              pass_r;
        logic              last_inflight;
        logic              accept;
        logic              mismatch;
        logic              frame_end;

        assign smp_dat = data_in[c*DATA_W +: DATA_W];
        assign ref_dat = exp_data[c*DATA_W +: DATA_W];

        // In single-shot the final sample must be the only compare in flight when the frame closes.
        assign last_inflight = pend && (pend_idx == LAST_IDX) && !mode_r;
        assign accept        = valid_in[c] && (st == ST_RUN) && !last_inflight;
        assign mismatch      = pend && (pend_dat != ref_dat);
        assign frame_end     = pend && (pend_idx == LAST_IDX);
        assign errs_nxt      = (mismatch && (errs != ERR_MAX)) ? errs + ERR_W'(1) : errs;

        always_ff @(posedge clk_ref or posedge reset) begin
            if (reset) begin
                st         <= ST_IDLE;
                idx        <= '0;
                pend       <= 1'b0;
                pend_idx   <= '0;
                pend_dat   <= '0;
                errs       <= '0;
                first_idx  <= '0;
                first_seen <= 1'b0;
                done_r     <= 1'b0;
                pass_r     <= 1'b0;
            end else if (start) begin
                st         <= ST_RUN;
                idx        <= '0;
                pend       <= 1'b0;
                errs       <= '0;
                first_idx  <= '0;
                first_seen <= 1'b0;
                done_r     <= 1'b0;
                pass_r     <= 1'b0;
            end else begin
                pend <= accept;
                if (accept) begin
                    pend_dat <= smp_dat;
                    pend_idx <= idx;
                    idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                if (pend) begin
                    errs <= errs_nxt;
                    if (mismatch && !first_seen) begin
                        first_idx  <= pend_idx;
                        first_seen <= 1'b1;
                    end
                end
                // Error count is cumulative since start, so pass sticks at 0 across continuous frames.
                if (frame_end) begin
                    done_r <= 1'b1;
                    pass_r <= (errs_nxt == '0);
                    if (!mode_r) begin
                        st <= ST_DONE;
                    end
                end else if (mode_r) begin
                    done_r <= 1'b0;
                end
            end
        end

        assign exp_addr[c*IDX_W +: IDX_W]      = idx;
        assign first_err_idx[c*IDX_W +: IDX_W] = first_idx;
        assign err_cnt[c*ERR_W +: ERR_W]       = errs;
        assign ready_out[c]                    = (st == ST_RUN);
        assign done[c]                         = done_r;
        assign pass[c]                         = pass_r;
    end

    // pass only rises after a completed frame, so a never-finished channel keeps this low.
    assign all_pass = &pass;

endmodule

// File: doc/phy_stage_checker.md
PHY_STAGE_CHECKER -- requirements
Module: phy_stage_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of independent check channels.
REQ-002 SHALL have parameter DATA_W, default 1, the bits per sample per channel.
REQ-003 SHALL have parameter VEC_LEN, default 192, the samples per reference frame (>=2); IDX_W = $clog2(VEC_LEN).
REQ-004 SHALL have parameter ERR_W, default 16, the width of each error counter.
REQ-005 clk_ref  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  arms or restarts all channels.
REQ-008 mode  in  1  0 = single-shot, 1 = continuous (frame wrap); sampled when start is accepted.
REQ-009 valid_in  in  NUM_CH  per-channel sample strobe.
REQ-010 data_in  in  NUM_CH*DATA_W  per-channel sample under test; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-011 exp_addr  out  NUM_CH*IDX_W  per-channel address to an external registered reference ROM.
REQ-012 exp_data  in  NUM_CH*DATA_W  ROM data, valid one clock after exp_addr.
REQ-013 ready_out  out  NUM_CH  high while the channel is in RUN.
REQ-014 done  out  NUM_CH  frame-complete indication per channel.
REQ-015 pass  out  NUM_CH  zero mismatches since the last start, valid once done has been seen.
REQ-016 err_cnt  out  NUM_CH*ERR_W  per-channel mismatch count.
REQ-017 first_err_idx  out  NUM_CH*IDX_W  frame index of the first mismatch.
REQ-018 all_pass  out  1  AND of pass over all channels.

Function
REQ-019 Each channel SHALL run an FSM with states IDLE, RUN and DONE; all channels share start and mode.
REQ-020 Transitions: IDLE/RUN/DONE -> RUN on start; in single-shot, RUN -> DONE when index VEC_LEN-1 is compared; continuous mode never enters DONE.
REQ-021 On start, a channel SHALL clear idx, err_cnt, first_err_idx, pass, done and any pending compare in the same edge.
REQ-022 If start and valid_in are high in the same cycle, start SHALL win and that sample SHALL be dropped.
REQ-023 exp_addr SHALL equal the channel's registered idx at all times.
REQ-024 Sample acceptance: valid_in && state==RUN SHALL register the data, the current idx and a pending flag, then increment idx.
REQ-025 idx SHALL wrap from VEC_LEN-1 to 0.
REQ-026 Samples with valid_in high outside RUN SHALL be ignored with no state change.
REQ-027 Compare stage: one cycle after acceptance, the registered data SHALL be compared with exp_data; a mismatch on any bit counts as one error.
REQ-028 err_cnt SHALL saturate at 2^ERR_W-1.
REQ-029 first_err_idx SHALL be written only on the first mismatch since start and held afterwards.
REQ-030 Latency: done and pass SHALL update on the edge after the edge that accepted sample VEC_LEN-1.
REQ-031 Single-shot: done SHALL be held high in DONE; pass = 1 iff err_cnt == 0 after the final compare.
REQ-032 Continuous: done SHALL pulse for 1 cycle per frame end; pass SHALL update at each frame end and, once 0, stay 0 until start.
REQ-033 Back-to-back valid_in every cycle SHALL be sustained with no bubbles; the compare pipeline is one deep per channel.
REQ-034 A compare pending when a single-shot frame ends cannot exist, since the last sample is the only one in flight.
REQ-035 all_pass SHALL be 1 only when every channel has pass=1; it is 0 if any channel has never completed a frame.
REQ-036 Channels SHALL be fully independent except for start, mode and all_pass.

Reset
REQ-037 Asserting reset SHALL immediately force all FSMs to IDLE and clear idx, pending flags, err_cnt, first_err_idx, done, pass, ready_out and all_pass to 0, regardless of clk_ref.
REQ-038 Reset mid-frame SHALL discard all progress; the checker stays in IDLE after reset deasserts until the next start.

Verification
REQ-039 NUM_CH=4, VEC_LEN=192, single-shot, all channels fed the exact reference -> done=4'hF one cycle after the 192nd sample; pass=4'hF, all_pass=1, err_cnt=0.
REQ-040 Channel 2 data bit flipped at indices 5 and 100 -> err_cnt[2]=2, first_err_idx[2]=5, pass[2]=0, all_pass=0; other channels pass.
REQ-041 Continuous mode, 3 frames, one error injected in frame 2 on ch0 -> done[0] pulses 3 times, pass[0] goes 1, 0, 0.
REQ-042 start asserted at sample 50 together with valid_in -> that sample is dropped, idx restarts at 0, err_cnt cleared, and a full 192-sample frame is then required before done.
REQ-043 ERR_W=4, every sample mismatched -> err_cnt saturates at 15, not wrapping.
REQ-044 reset asserted mid-frame between clock edges -> all outputs 0 immediately; valid_in after deassertion is ignored until start.
